// File: rtl/fsm_mealy_moore.sv
// Overlapping "11" detector built as a Mealy and a Moore machine sharing clk/reset/x.
// Optional FSM_MISMATCH_FLAG_EN adds a registered Mealy copy and a mismatch output.
module fsm_mealy_moore (
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic q_mealy,
  output logic q_moore
`ifdef FSM_MISMATCH_FLAG_EN
  ,
  output logic mismatch
`endif
);

  typedef enum logic {
    M_ZERO = 1'b0,
    M_ONE  = 1'b1
  } mealy_state_e;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } moore_state_e;

  mealy_state_e mealy_state_q, mealy_state_d;
  moore_state_e moore_state_q, moore_state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mealy_state_q <= M_ZERO;
      moore_state_q <= S0;
    end else begin
      mealy_state_q <= mealy_state_d;
      moore_state_q <= moore_state_d;
    end
  end

  always_comb begin
    mealy_state_d = M_ZERO;
    if (x) mealy_state_d = M_ONE;
    q_mealy = (mealy_state_q == M_ONE) & x;
  end

  // Encoding 2'b11 falls into the default arm and recovers to S0.
  always_comb begin
    moore_state_d = S0;
    case (moore_state_q)
      S0:      moore_state_d = x ? S1 : S0;
      S1:      moore_state_d = x ? S2 : S0;
      S2:      moore_state_d = x ? S2 : S0;
      default: moore_state_d = S0;
    endcase
    q_moore = (moore_state_q == S2);
  end

`ifdef FSM_MISMATCH_FLAG_EN
  logic q_mealy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_mealy_d <= 1'b0;
    else       q_mealy_d <= q_mealy;
  end

  always_comb begin
    mismatch = q_mealy_d ^ q_moore;
  end
`endif

endmodule

// File: tb/tb_fsm_mealy_moore.sv
// Self-checking bench for fsm_mealy_moore: vector table, hand-written reset cases,
// and a random stream checked against a one-bit reference model via a scoreboard.
module tb_fsm_mealy_moore;

  logic clk;
  logic reset;
  logic x;
  logic q_mealy;
  logic q_moore;
`ifdef FSM_MISMATCH_FLAG_EN
  logic mismatch;
`endif

  fsm_mealy_moore dut (
    .clk     (clk),
    .reset   (reset),
    .x       (x),
    .q_mealy (q_mealy),
    .q_moore (q_moore)
`ifdef FSM_MISMATCH_FLAG_EN
    ,
    .mismatch(mismatch)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic m;
    logic o;
  } exp_t;

  typedef struct packed {
    logic x;
    logic m;
    logic o;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[14];
  int   checks   = 0;
  int   failures = 0;
  logic prev1    = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_mismatch();
`ifdef FSM_MISMATCH_FLAG_EN
    chk("mismatch", mismatch, 1'b0);
`endif
  endtask

  // Drive one bit on the falling edge, sample Mealy mid-cycle, Moore after the edge.
  task automatic apply(input logic xv, input logic em, input logic eo);
    exp_t e;
    logic mealy_s;
    @(negedge clk);
    x = xv;
    sbq.push_back('{m: em, o: eo});
    #2;
    mealy_s = q_mealy;
    @(posedge clk);
    #1;
    prev1 = xv;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = sbq.pop_front();
      chk("q_mealy", mealy_s, e.m);
      chk("q_moore", q_moore, e.o);
      chk_mismatch();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic xv;
    logic em;

    //          x     mealy  moore
    vecs[0]  = '{1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    x     = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      x = ~x;
      #2;
      chk("reset_q_mealy_mid", q_mealy, 1'b0);
      @(posedge clk);
      #1;
      chk("reset_q_mealy", q_mealy, 1'b0);
      chk("reset_q_moore", q_moore, 1'b0);
      chk_mismatch();
    end

    @(negedge clk);
    reset = 1'b0;
    x     = 1'b0;
    prev1 = 1'b0;

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].x, vecs[i].m, vecs[i].o);
    end

    // Reach S2/M_ONE, then assert reset asynchronously between edges.
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    #2;
    chk("pre_async_q_mealy", q_mealy, 1'b1);
    chk("pre_async_q_moore", q_moore, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_q_mealy", q_mealy, 1'b0);
    chk("async_q_moore", q_moore, 1'b0);
    @(posedge clk);
    #1;
    chk("held_q_mealy", q_mealy, 1'b0);
    chk("held_q_moore", q_moore, 1'b0);
    chk_mismatch();
    @(negedge clk);
    reset = 1'b0;
    x     = 1'b1;
    #2;
    chk("post_rel_q_mealy", q_mealy, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rel_q_moore", q_moore, 1'b0);
    chk_mismatch();
    prev1 = 1'b1;
    apply(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      xv = 1'($urandom_range(0, 1));
      em = prev1 & xv;
      apply(xv, em, em);
    end

    if (sbq.size() != 0) chk("scoreboard_drain", 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
